// File: rtl/ws_pkg.sv
// Shared types and helpers for the weight-stationary result drain.
package ws_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_t;

  // Widest intermediate the saturator accepts. Callers sign-extend into it.
  localparam int SAT_W = 64;

  // Clamp a signed value to the range of a dw-bit two's complement number.
  function automatic logic signed [SAT_W-1:0] sat_to_dw(input logic signed [SAT_W-1:0] y,
                                                        input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (y > hi) return hi;
    else if (y < lo) return lo;
    return y;
  endfunction

endpackage

// File: rtl/ws_requant.sv
// Combinational requantizer: rounding arithmetic right shift, then saturation to DATA_WIDTH.
// Negative results are forced to zero when WS_DRAIN_RELU_EN is defined.
module ws_requant
  import ws_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic [2*DATA_WIDTH-1:0] x,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [DATA_WIDTH-1:0]   y
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int RW = AW + 1;

  logic signed [RW-1:0]    x_ext;
  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    sum;
  logic signed [RW-1:0]    shifted;
  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] sat;
  logic [DATA_WIDTH-1:0]   q;
  logic                    unused_sat_hi;

  // One extra bit of headroom so the rounding add on the largest positive input cannot wrap.
  // NOTE: every combinational output gets a default at the top of the block, so no latch is inferred.
  always_comb begin
    x_ext = {x[AW-1], x};
    rnd   = '0;
    if (shift != '0) rnd = RW'(1) << (shift - 1'b1);
    sum     = x_ext + rnd;
    shifted = sum >>> shift;
    wide    = {{(SAT_W - RW){shifted[RW-1]}}, shifted};
    sat     = sat_to_dw(wide, DATA_WIDTH);
    q       = sat[DATA_WIDTH-1:0];
`ifdef WS_DRAIN_RELU_EN
    if (q[DATA_WIDTH-1]) q = '0;
`else
    q = q;
`endif
    y = q;
  end

  assign unused_sat_hi = ^sat[SAT_W-1:DATA_WIDTH];

endmodule

// File: rtl/ws_result_drain.sv
// Snapshots the systolic array's accumulator matrix on done_in and streams requantized
// elements row-major over valid/ready. Optional WS_DRAIN_RELU_EN clamps negatives to zero.
module ws_result_drain
  import ws_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int SHIFT_W    = 5,
  localparam int RIW       = (M > 1) ? $clog2(M) : 1,
  localparam int CIW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     done_in,
  input  logic [M-1:0][N-1:0][2*DATA_WIDTH-1:0]    c_in,
  input  logic [SHIFT_W-1:0]                       shift_amt,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [RIW-1:0]                           out_row,
  output logic [CIW-1:0]                           out_col,
  output logic                                     out_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int AW = 2 * DATA_WIDTH;

  drain_state_t state, state_d;
  logic         capture;
  logic         advance;

  logic [M-1:0][N-1:0][AW-1:0] snap;
  logic [SHIFT_W-1:0]          snap_shift;

  logic [RIW-1:0]        nrow;
  logic [CIW-1:0]        ncol;
  logic                  nlast;
  logic [AW-1:0]         rq_x;
  logic [SHIFT_W-1:0]    rq_shift;
  logic [DATA_WIDTH-1:0] rq_y;

  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state)
      IDLE: if (done_in) begin
        state_d = EMIT;
        capture = 1'b1;
      end
      EMIT: if (out_ready) begin
        advance = 1'b1;
        if (out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);

  // Index of the element that follows the one currently presented.
  always_comb begin
    nrow = out_row;
    ncol = out_col + 1'b1;
    if (out_col == CIW'(N - 1)) begin
      ncol = '0;
      nrow = out_row + 1'b1;
    end
    nlast = (nrow == RIW'(M - 1)) && (ncol == CIW'(N - 1));
  end

  // On capture the snapshot is not yet loaded, so element [0][0] comes straight from c_in.
  always_comb begin
    rq_x     = snap[nrow][ncol];
    rq_shift = snap_shift;
    if (capture) begin
      rq_x     = c_in[0][0];
      rq_shift = shift_amt;
    end
  end

  ws_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_W    (SHIFT_W)
  ) u_requant (
    .x     (rq_x),
    .shift (rq_shift),
    .y     (rq_y)
  );

  // NOTE: the snapshot is a plain storage array with no reset; its contents are only
  // read after a capture has written them.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap       <= c_in;
      snap_shift <= shift_amt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_last <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (done_in && state == EMIT) overrun <= 1'b1;
      if (capture) begin
        out_data <= rq_y;
        out_row  <= '0;
        out_col  <= '0;
        out_last <= (M == 1) && (N == 1);
      end else if (advance && !out_last) begin
        out_data <= rq_y;
        out_row  <= nrow;
        out_col  <= ncol;
        out_last <= nlast;
      end
    end
  end

endmodule

// File: tb/tb_ws_result_drain.sv
// Directed bench for ws_result_drain (DW=16, M=N=4); honours WS_DRAIN_RELU_EN in its expectations.
module tb_ws_result_drain;

  localparam int DW = 16;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int SW = 5;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            done_in;
  logic [M-1:0][N-1:0][2*DW-1:0]   c_in;
  logic [SW-1:0]                   shift_amt;
  logic [DW-1:0]                   out_data;
  logic [1:0]                      out_row;
  logic [1:0]                      out_col;
  logic                            out_last;
  logic                            out_valid;
  logic                            out_ready;
  logic                            busy;
  logic                            overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_data [16];

  always #5 clk = ~clk;

  ws_result_drain #(
    .DATA_WIDTH (DW),
    .M          (M),
    .N          (N),
    .SHIFT_W    (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_in   (done_in),
    .c_in      (c_in),
    .shift_amt (shift_amt),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef WS_DRAIN_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic clear_matrix();
    c_in = '0;
    for (int i = 0; i < 16; i++) exp_data[i] = '0;
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < 16; i++) begin
      c_in[i/4][i%4] = 32'(base + i);
      exp_data[i]    = 16'(base + i);
    end
  endtask

  // Called at a negedge; done_in is seen by the next posedge, then c_in is scrambled.
  task automatic pulse_done(input logic [SW-1:0] s);
    done_in   = 1'b1;
    shift_amt = s;
    @(negedge clk);
    done_in   = 1'b0;
    shift_amt = 5'd7;
    c_in      = {16{32'hDEAD_BEEF}};
  endtask

  task automatic drain(input string tag, input int stall_pct, input int first,
                       input int last_b, output int cycles);
    int            b;
    logic          stalled;
    logic [DW+4:0] saved;
    logic [DW+4:0] now;
    logic [DW+4:0] expv;
    b = first; stalled = 1'b0; cycles = 0; saved = '0;
    while (b < last_b && cycles < 400) begin
      if (out_valid) begin
        now = {out_data, out_row, out_col, out_last};
        if (stalled) begin
          vectors++;
          if (now !== saved) begin
            miscompares++;
            $display("FAIL %s_hold beat %0d: got %h, required %h", tag, b, now, saved);
          end
        end
        expv = {exp_data[b], 2'(b / 4), 2'(b % 4), (b == 15)};
        vectors++;
        if (now !== expv) begin
          miscompares++;
          $display("FAIL %s beat %0d {data,row,col,last}: got %h, required %h", tag, b, now, expv);
        end
        if ($urandom_range(0, 99) >= stall_pct) begin
          out_ready = 1'b1; b++; stalled = 1'b0;
        end else begin
          out_ready = 1'b0; stalled = 1'b1; saved = now;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    vectors++;
    if (b < last_b) begin
      miscompares++;
      $display("FAIL %s_timeout: reached beat %0d, required %0d", tag, b, last_b);
    end
  endtask

  task automatic expect_idle(input string tag);
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s {valid,busy}: got %b, required 00", tag, {out_valid, busy});
    end
  endtask

  task automatic expect_started(input string tag);
    vectors++;
    if ({out_valid, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL %s {valid,busy}: got %b, required 11", tag, {out_valid, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done_in = 1'b0; c_in = '0; shift_amt = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, busy, overrun, out_last, out_data, out_row, out_col} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v%b b%b o%b l%b d%h r%0d c%0d, required all 0",
               out_valid, busy, overrun, out_last, out_data, out_row, out_col);
    end
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("reset_release");
  endtask

  task automatic test_stream();
    int cyc;
    load_ramp(0);
    pulse_done(5'd0);
    expect_started("stream_latency");
    drain("stream", 0, 0, 16, cyc);
    vectors++;
    if (cyc !== 16) begin
      miscompares++;
      $display("FAIL stream_cycles: got %0d, required 16", cyc);
    end
    expect_idle("stream_end");
  endtask

  task automatic test_rounding();
    int cyc;
    clear_matrix();
    c_in[0][0] = 32'h0001_8000; exp_data[0] = relu(16'h0002);
    c_in[0][1] = 32'h0001_7FFF; exp_data[1] = relu(16'h0001);
    c_in[0][2] = 32'hFFFF_8000; exp_data[2] = relu(16'h0000);
    c_in[0][3] = 32'hFFFF_7FFF; exp_data[3] = relu(16'hFFFF);
    pulse_done(5'd16);
    drain("round_s16", 0, 0, 16, cyc);
    clear_matrix();
    c_in[0][0] = 32'hFFFF_FFFD; exp_data[0] = relu(16'hFFFF);
    c_in[0][1] = 32'h0000_0003; exp_data[1] = relu(16'h0002);
    c_in[0][2] = 32'hFFFF_FFFF; exp_data[2] = relu(16'h0000);
    c_in[0][3] = 32'h7FFF_FFFF; exp_data[3] = relu(16'h7FFF);
    c_in[1][0] = 32'hFFFF_FFFC; exp_data[4] = relu(16'hFFFE);
    c_in[1][1] = 32'h0000_0005; exp_data[5] = relu(16'h0003);
    pulse_done(5'd1);
    drain("round_s1", 0, 0, 16, cyc);
  endtask

  task automatic test_saturation();
    int cyc;
    clear_matrix();
    c_in[0][0] = 32'h7FFF_FFFF; exp_data[0] = relu(16'h7FFF);
    c_in[0][1] = 32'h8000_0000; exp_data[1] = relu(16'h8000);
    c_in[0][2] = 32'h0000_7FFF; exp_data[2] = relu(16'h7FFF);
    c_in[0][3] = 32'h0000_8000; exp_data[3] = relu(16'h7FFF);
    c_in[1][0] = 32'hFFFF_8000; exp_data[4] = relu(16'h8000);
    c_in[1][1] = 32'hFFFF_7FFF; exp_data[5] = relu(16'h8000);
    c_in[1][2] = 32'hFFFF_FFFF; exp_data[6] = relu(16'hFFFF);
    pulse_done(5'd0);
    drain("saturate", 0, 0, 16, cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    load_ramp(0);
    pulse_done(5'd0);
    drain("backpressure", 30, 0, 16, cyc);
    expect_idle("backpressure_end");
  endtask

  task automatic test_overrun();
    int cyc;
    load_ramp(0);
    pulse_done(5'd0);
    drain("overrun_pre", 0, 0, 5, cyc);
    c_in = {16{32'h1234_5678}};
    pulse_done(5'd3);
    vectors++;
    if ({overrun, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL overrun_set {overrun,busy}: got %b, required 11", {overrun, busy});
    end
    drain("overrun_post", 0, 5, 16, cyc);
    expect_idle("overrun_end");
    load_ramp(100);
    pulse_done(5'd0);
    expect_started("overrun_recapture");
    drain("overrun_recap", 0, 0, 16, cyc);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    load_ramp(0);
    pulse_done(5'd0);
    drain("abort_pre", 0, 0, 7, cyc);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, overrun, out_data} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got v%b b%b o%b d%h, required all 0",
               out_valid, busy, overrun, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("abort_release");
    load_ramp(200);
    pulse_done(5'd0);
    expect_started("abort_restart");
    drain("abort_restart", 0, 0, 16, cyc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
